vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator, the successor to the fixed 800x600 timing constants.
- Holds two complete timing sets (MODE0, MODE1) plus per-set sync polarity.
- Mode is selected at run time and takes effect only at a frame boundary.
- Sits at the head of the video pipeline; drives hcount/vcount/sync/blank into draw_bg, draw_rect and font stages.

Parameters:
- CNT_W, 11, width of hcount/vcount.
- M0_H_PIX / M0_H_BLK_S / M0_H_BLK_E / M0_H_SYN_S / M0_H_SYN_E, 800/800/1055/840/967, mode-0 horizontal timing (BLK_E = line total - 1).
- M0_V_PIX / M0_V_BLK_S / M0_V_BLK_E / M0_V_SYN_S / M0_V_SYN_E, 600/600/627/601/604, mode-0 vertical timing.
- M0_HS_POL / M0_VS_POL, 1/1, sync active level (1 = active-high).
- M1_* (same ten fields), 640/640/799/656/751 horizontal and 480/480/524/490/491 vertical, mode-1 timing.
- M1_HS_POL / M1_VS_POL, 0/0.

Ports:
- clk  in  1  pixel clock (generating the clock for each mode is outside this block)
- rst_n  in  1  asynchronous active-low reset
- mode_sel  in  1  requested mode (0/1), sampled every cycle
- hcount  out  CNT_W  horizontal position
- vcount  out  CNT_W  vertical position
- hsync  out  1  horizontal sync, polarity per active mode
- vsync  out  1  vertical sync, polarity per active mode
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- frame_start  out  1  one-cycle pulse when hcount=0 and vcount=0
- mode_act  out  1  mode currently in effect

Behaviour:
- Reset (async assert, sync release):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, mode_act=0.
  - hsync/vsync are at the inactive level of mode 0.
  - First rising edge after release produces hcount=1.
- Counters:
  - hcount increments each cycle. At H_BLK_E it wraps to 0 and vcount increments.
  - When vcount=V_BLK_E and hcount=H_BLK_E, both wrap to 0 (frame end).
- Registered outputs:
  - All outputs are registered. Flags are computed from the next counter values, so flags and counters for a given pixel appear in the same cycle (zero relative skew, one register stage).
- Flag rules (inclusive comparisons, active-mode values):
  - hblnk = H_BLK_S <= hcount <= H_BLK_E.
  - vblnk = V_BLK_S <= vcount <= V_BLK_E.
  - hsync asserted (at HS_POL) for H_SYN_S <= hcount <= H_SYN_E.
  - vsync asserted (at VS_POL) for V_SYN_S <= vcount <= V_SYN_E.
- frame_start is high exactly in the cycle where the registered counters read (0,0).
- Mode switching, two-state FSM:
  - RUN: mode_sel differs from mode_act → go to PEND.
  - PEND: at the frame-end cycle, mode_act takes the value of mode_sel at that cycle and the FSM returns to RUN. The next cycle's counters (0,0) and flags already use the new set.
  - PEND: if mode_sel returns to mode_act before frame end → back to RUN, no switch.
- Switching never truncates or extends a frame. The old frame always completes with the old timing.
- Arithmetic:
  - Counters use unsigned CNT_W compares.
  - Parameters must satisfy PIX <= SYN_S <= SYN_E <= BLK_E < 2^CNT_W. An elaboration-time check fails otherwise.
- Reset mid-frame: immediate return to reset values and mode 0. A pending mode request is discarded.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0]: clears on reset, increments at every frame end, wraps 0xFFFF→0.
  - Frame end includes the frame where a mode switch is applied.
- Undefined: port and counter absent; all other behaviour unchanged.

Decomposition:
- vga_pkg gains typedef struct vga_timing_t with the ten timing fields and two polarity bits.
- vga_pkg gains localparams VGA_800x600_60 and VGA_640x480_60 of that type. Defaults of the M0_*/M1_* parameters are taken from them.
- vga_pkg gains localparam CNT_W_DEF = 11.
- One natural sub-module: vga_tim_axis, instantiated for horizontal and vertical.
  - Counter, wrap detect and blank/sync compare for one axis.
  - Enable input; terminal-count output.
- The top holds the mode FSM and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, release → all outputs at reset values; after 1 edge hcount=1; after 1056 edges hcount=0, vcount=1.
- Mode-0 horizontal flags: hsync=1 exactly for hcount 840..967 (128 cycles); hblnk=1 for 800..1055; no skew against hcount.
- Mode-0 frame: vblnk=1 for vcount 600..627, vsync=1 for 601..604. frame_start pulses every 1056*628 = 663168 cycles.
- Mode switch: set mode_sel=1 at vcount=300 → mode_act stays 0 until frame end, then 1.
  - Next frame: hblnk from hcount 640, line length 800, hsync low for 656..751, frame length 420000 cycles.
- Aborted request: mode_sel=1 at vcount=100, back to 0 at vcount=200 → no switch, frame length unchanged.
- Reset mid-frame: in mode 1 at vcount=250, pulse rst_n low for 1 cycle → immediate reset values, mode_act=0; with VGA_TIMING_FRAME_CNT_EN, frame_cnt=0 and reaches 3 after three full mode-0 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator: timing-set struct,
// the two standard timing sets, the mode FSM encoding and a parameter sanity helper.
package vga_pkg;

    localparam int unsigned CNT_W_DEF = 11;

    typedef struct packed {
        int unsigned h_pix;
        int unsigned h_blk_s;
        int unsigned h_blk_e;
        int unsigned h_syn_s;
        int unsigned h_syn_e;
        int unsigned v_pix;
        int unsigned v_blk_s;
        int unsigned v_blk_e;
        int unsigned v_syn_s;
        int unsigned v_syn_e;
        bit          hs_pol;
        bit          vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_800x600_60 = '{
        h_pix: 800, h_blk_s: 800, h_blk_e: 1055, h_syn_s: 840, h_syn_e: 967,
        v_pix: 600, v_blk_s: 600, v_blk_e: 627,  v_syn_s: 601, v_syn_e: 604,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    localparam vga_timing_t VGA_640x480_60 = '{
        h_pix: 640, h_blk_s: 640, h_blk_e: 799, h_syn_s: 656, h_syn_e: 751,
        v_pix: 480, v_blk_s: 480, v_blk_e: 524, v_syn_s: 490, v_syn_e: 491,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_PEND = 1'b1
    } mode_state_e;

    // True when one axis is ordered PIX <= SYN_S <= SYN_E <= BLK_E and BLK_E fits the counter.
    function automatic bit axis_ok(input int unsigned pix, input int unsigned syn_s,
                                   input int unsigned syn_e, input int unsigned blk_e,
                                   input int unsigned cnt_w);
        return (pix <= syn_s) && (syn_s <= syn_e) && (syn_e <= blk_e) &&
               ((cnt_w >= 32) || ((blk_e >> cnt_w) == 0));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between vga_timing_gen (master) and the draw stages (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             mode_sel;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             frame_start;
    logic             mode_act;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        input  mode_sel,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act, frame_cnt
    );
    modport slave (
        output mode_sel,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act, frame_cnt
    );
`else
    modport master (
        input  mode_sel,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act
    );
    modport slave (
        output mode_sel,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_act
    );
`endif
endinterface

// File: rtl/vga_tim_axis.sv
// One timing axis: position counter with wrap detect plus registered blank/sync flags
// derived from the next count, so flags and count leave in the same cycle.
module vga_tim_axis #(
    parameter int unsigned CNT_W   = 11,
    parameter bit          SYN_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] end_i,
    input  logic [CNT_W-1:0] blk_s_i,
    input  logic [CNT_W-1:0] blk_e_i,
    input  logic [CNT_W-1:0] syn_s_i,
    input  logic [CNT_W-1:0] syn_e_i,
    input  logic             syn_pol_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             blk_o,
    output logic             syn_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blk_q, blk_d;
    logic             syn_q, syn_d;

    assign tc_o = (cnt_q == end_i);

    // end_i belongs to the timing set in force now; the compare bounds belong to the set
    // in force for the next pixel, which differ only across a mode-switch frame boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
        blk_d = (cnt_d >= blk_s_i) && (cnt_d <= blk_e_i);
        syn_d = ((cnt_d >= syn_s_i) && (cnt_d <= syn_e_i)) ? syn_pol_i : ~syn_pol_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            blk_q <= 1'b0;
            syn_q <= SYN_RST;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
            syn_q <= syn_d;
        end
    end

    assign cnt_o = cnt_q;
    assign blk_o = blk_q;
    assign syn_o = syn_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator; mode requests are applied only at a frame boundary.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned M0_H_PIX   = VGA_800x600_60.h_pix,
    parameter int unsigned M0_H_BLK_S = VGA_800x600_60.h_blk_s,
    parameter int unsigned M0_H_BLK_E = VGA_800x600_60.h_blk_e,
    parameter int unsigned M0_H_SYN_S = VGA_800x600_60.h_syn_s,
    parameter int unsigned M0_H_SYN_E = VGA_800x600_60.h_syn_e,
    parameter int unsigned M0_V_PIX   = VGA_800x600_60.v_pix,
    parameter int unsigned M0_V_BLK_S = VGA_800x600_60.v_blk_s,
    parameter int unsigned M0_V_BLK_E = VGA_800x600_60.v_blk_e,
    parameter int unsigned M0_V_SYN_S = VGA_800x600_60.v_syn_s,
    parameter int unsigned M0_V_SYN_E = VGA_800x600_60.v_syn_e,
    parameter bit          M0_HS_POL  = VGA_800x600_60.hs_pol,
    parameter bit          M0_VS_POL  = VGA_800x600_60.vs_pol,
    parameter int unsigned M1_H_PIX   = VGA_640x480_60.h_pix,
    parameter int unsigned M1_H_BLK_S = VGA_640x480_60.h_blk_s,
    parameter int unsigned M1_H_BLK_E = VGA_640x480_60.h_blk_e,
    parameter int unsigned M1_H_SYN_S = VGA_640x480_60.h_syn_s,
    parameter int unsigned M1_H_SYN_E = VGA_640x480_60.h_syn_e,
    parameter int unsigned M1_V_PIX   = VGA_640x480_60.v_pix,
    parameter int unsigned M1_V_BLK_S = VGA_640x480_60.v_blk_s,
    parameter int unsigned M1_V_BLK_E = VGA_640x480_60.v_blk_e,
    parameter int unsigned M1_V_SYN_S = VGA_640x480_60.v_syn_s,
    parameter int unsigned M1_V_SYN_E = VGA_640x480_60.v_syn_e,
    parameter bit          M1_HS_POL  = VGA_640x480_60.hs_pol,
    parameter bit          M1_VS_POL  = VGA_640x480_60.vs_pol
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master vga
);

    if (!axis_ok(M0_H_PIX, M0_H_SYN_S, M0_H_SYN_E, M0_H_BLK_E, CNT_W)) begin : g_bad_m0_h
        $error("vga_timing_gen: mode-0 horizontal timing out of order or too wide");
    end
    if (!axis_ok(M0_V_PIX, M0_V_SYN_S, M0_V_SYN_E, M0_V_BLK_E, CNT_W)) begin : g_bad_m0_v
        $error("vga_timing_gen: mode-0 vertical timing out of order or too wide");
    end
    if (!axis_ok(M1_H_PIX, M1_H_SYN_S, M1_H_SYN_E, M1_H_BLK_E, CNT_W)) begin : g_bad_m1_h
        $error("vga_timing_gen: mode-1 horizontal timing out of order or too wide");
    end
    if (!axis_ok(M1_V_PIX, M1_V_SYN_S, M1_V_SYN_E, M1_V_BLK_E, CNT_W)) begin : g_bad_m1_v
        $error("vga_timing_gen: mode-1 vertical timing out of order or too wide");
    end

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H0_BS = cnt_t'(M0_H_BLK_S);
    localparam cnt_t H0_BE = cnt_t'(M0_H_BLK_E);
    localparam cnt_t H0_SS = cnt_t'(M0_H_SYN_S);
    localparam cnt_t H0_SE = cnt_t'(M0_H_SYN_E);
    localparam cnt_t V0_BS = cnt_t'(M0_V_BLK_S);
    localparam cnt_t V0_BE = cnt_t'(M0_V_BLK_E);
    localparam cnt_t V0_SS = cnt_t'(M0_V_SYN_S);
    localparam cnt_t V0_SE = cnt_t'(M0_V_SYN_E);
    localparam cnt_t H1_BS = cnt_t'(M1_H_BLK_S);
    localparam cnt_t H1_BE = cnt_t'(M1_H_BLK_E);
    localparam cnt_t H1_SS = cnt_t'(M1_H_SYN_S);
    localparam cnt_t H1_SE = cnt_t'(M1_H_SYN_E);
    localparam cnt_t V1_BS = cnt_t'(M1_V_BLK_S);
    localparam cnt_t V1_BE = cnt_t'(M1_V_BLK_E);
    localparam cnt_t V1_SS = cnt_t'(M1_V_SYN_S);
    localparam cnt_t V1_SE = cnt_t'(M1_V_SYN_E);

    mode_state_e state_q, state_d;
    logic        mode_act_q, mode_act_d;
    logic        frame_start_q;
    logic        h_tc, v_tc, frame_end;
    cnt_t        h_end, v_end;
    cnt_t        h_bs, h_be, h_ss, h_se;
    cnt_t        v_bs, v_be, v_ss, v_se;
    logic        hs_pol, vs_pol;

    assign frame_end = h_tc & v_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MODE_RUN;
            mode_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_act_q <= mode_act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MODE_RUN: begin
                if (vga.mode_sel != mode_act_q) state_d = MODE_PEND;
            end
            MODE_PEND: begin
                if (frame_end || (vga.mode_sel == mode_act_q)) state_d = MODE_RUN;
            end
        endcase
    end

    always_comb begin
        mode_act_d = mode_act_q;
        if ((state_q == MODE_PEND) && frame_end) mode_act_d = vga.mode_sel;
    end

    // Wrap points follow the mode in force; flag bounds follow the mode of the next pixel.
    always_comb begin
        h_end  = mode_act_q ? H1_BE : H0_BE;
        v_end  = mode_act_q ? V1_BE : V0_BE;
        h_bs   = mode_act_d ? H1_BS : H0_BS;
        h_be   = mode_act_d ? H1_BE : H0_BE;
        h_ss   = mode_act_d ? H1_SS : H0_SS;
        h_se   = mode_act_d ? H1_SE : H0_SE;
        v_bs   = mode_act_d ? V1_BS : V0_BS;
        v_be   = mode_act_d ? V1_BE : V0_BE;
        v_ss   = mode_act_d ? V1_SS : V0_SS;
        v_se   = mode_act_d ? V1_SE : V0_SE;
        hs_pol = mode_act_d ? M1_HS_POL : M0_HS_POL;
        vs_pol = mode_act_d ? M1_VS_POL : M0_VS_POL;
    end

    vga_tim_axis #(.CNT_W(CNT_W), .SYN_RST(~M0_HS_POL)) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (1'b1),
        .end_i     (h_end),
        .blk_s_i   (h_bs),
        .blk_e_i   (h_be),
        .syn_s_i   (h_ss),
        .syn_e_i   (h_se),
        .syn_pol_i (hs_pol),
        .cnt_o     (vga.hcount),
        .blk_o     (vga.hblnk),
        .syn_o     (vga.hsync),
        .tc_o      (h_tc)
    );

    vga_tim_axis #(.CNT_W(CNT_W), .SYN_RST(~M0_VS_POL)) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (h_tc),
        .end_i     (v_end),
        .blk_s_i   (v_bs),
        .blk_e_i   (v_be),
        .syn_s_i   (v_ss),
        .syn_e_i   (v_se),
        .syn_pol_i (vs_pol),
        .cnt_o     (vga.vcount),
        .blk_o     (vga.vblnk),
        .syn_o     (vga.vsync),
        .tc_o      (v_tc)
    );

    // The counters land on (0,0) exactly one cycle after frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_end;
        end
    end

    assign vga.frame_start = frame_start_q;
    assign vga.mode_act    = mode_act_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`else
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using shrunken timing sets so whole frames fit in a short run;
// outputs are compared against a pixel-position model of the timing rules.
module tb_vga_timing_gen;

    localparam int unsigned CW = 11;
    localparam int unsigned H0_PIX = 20, H0_BS = 20, H0_BE = 31, H0_SS = 23, H0_SE = 26;
    localparam int unsigned V0_PIX = 10, V0_BS = 10, V0_BE = 14, V0_SS = 11, V0_SE = 12;
    localparam int unsigned H1_PIX = 12, H1_BS = 12, H1_BE = 19, H1_SS = 14, H1_SE = 19;
    localparam int unsigned V1_PIX = 6,  V1_BS = 6,  V1_BE = 9,  V1_SS = 7,  V1_SE = 7;
    localparam int unsigned FRAME0 = 480;
    localparam int unsigned FRAME1 = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_timing_gen_if #(.CNT_W(CW)) vif ();

    vga_timing_gen #(
        .CNT_W(CW),
        .M0_H_PIX(H0_PIX), .M0_H_BLK_S(H0_BS), .M0_H_BLK_E(H0_BE), .M0_H_SYN_S(H0_SS), .M0_H_SYN_E(H0_SE),
        .M0_V_PIX(V0_PIX), .M0_V_BLK_S(V0_BS), .M0_V_BLK_E(V0_BE), .M0_V_SYN_S(V0_SS), .M0_V_SYN_E(V0_SE),
        .M0_HS_POL(1'b1), .M0_VS_POL(1'b1),
        .M1_H_PIX(H1_PIX), .M1_H_BLK_S(H1_BS), .M1_H_BLK_E(H1_BE), .M1_H_SYN_S(H1_SS), .M1_H_SYN_E(H1_SE),
        .M1_V_PIX(V1_PIX), .M1_V_BLK_S(V1_BS), .M1_V_BLK_E(V1_BE), .M1_V_SYN_S(V1_SS), .M1_V_SYN_E(V1_SE),
        .M1_HS_POL(1'b0), .M1_VS_POL(1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Timing tables: line/frame totals and the inclusive flag windows per mode.
    int unsigned M_HT  [2] = '{32, 20};
    int unsigned M_VT  [2] = '{15, 10};
    int unsigned M_HBS [2] = '{H0_BS, H1_BS};
    int unsigned M_HSS [2] = '{H0_SS, H1_SS};
    int unsigned M_HSE [2] = '{H0_SE, H1_SE};
    int unsigned M_VBS [2] = '{V0_BS, V1_BS};
    int unsigned M_VSS [2] = '{V0_SS, V1_SS};
    int unsigned M_VSE [2] = '{V0_SE, V1_SE};
    bit          M_HP  [2] = '{1'b1, 1'b0};
    bit          M_VP  [2] = '{1'b1, 1'b0};

    int unsigned mh, mv, mfcnt;
    bit          mmode, mreq, mfs;

    task automatic model_reset();
        mh = 0; mv = 0; mmode = 1'b0; mreq = 1'b0; mfs = 1'b0; mfcnt = 0;
    endtask

    // Advance the model one pixel using the mode request seen at this clock edge.
    task automatic model_step();
        int unsigned m = mmode ? 1 : 0;
        bit sel = vif.mode_sel;
        bit old = mmode;
        bit fe  = (mh == M_HT[m] - 1) && (mv == M_VT[m] - 1);
        if (mreq && fe) mmode = sel;
        if (!mreq) mreq = (sel != old);
        else       mreq = !(fe || (sel == old));
        if (mh == M_HT[m] - 1) begin
            mh = 0;
            mv = (mv == M_VT[m] - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        mfs = fe;
        if (fe) mfcnt = (mfcnt + 1) % 65536;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    function automatic logic [27:0] obs();
        return {vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.hblnk, vif.vblnk,
                vif.frame_start, vif.mode_act};
    endfunction

    function automatic logic [27:0] expv();
        int unsigned m = mmode ? 1 : 0;
        logic hs, vs, hb, vb;
        hs = (mh >= M_HSS[m] && mh <= M_HSE[m]) ? M_HP[m] : ~M_HP[m];
        vs = (mv >= M_VSS[m] && mv <= M_VSE[m]) ? M_VP[m] : ~M_VP[m];
        hb = (mh >= M_HBS[m]);
        vb = (mv >= M_VBS[m]);
        return {11'(mh), 11'(mv), hs, vs, hb, vb, mfs, mmode};
    endfunction

    task automatic wait_v(input int unsigned v, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (vif.vcount == 11'(v)) begin
                hit = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        vif.mode_sel = 1'b0;
        rst_n = 1'b0;
        repeat (5) tick();
        checks++;
        if (obs() !== 28'd0) begin
            failures++;
            $display("[TB] FAIL reset_values got=%h exp=%h", obs(), 28'd0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (vif.hcount !== 11'd1) begin
            failures++;
            $display("[TB] FAIL first_edge_hcount got=%0d exp=1", vif.hcount);
        end
        repeat (31) tick();
        checks++;
        if (vif.hcount !== 11'd0 || vif.vcount !== 11'd1) begin
            failures++;
            $display("[TB] FAIL line_wrap got=(%0d,%0d) exp=(0,1)", vif.hcount, vif.vcount);
        end
    endtask

    task automatic test_mode0_frame();
        int hs_n = 0, vs_n = 0, hb_n = 0, vb_n = 0;
        for (int i = 0; i < 1000 && !vif.frame_start; i++) tick();
        checks++;
        if (vif.frame_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL m0_frame_start_seen got=%b exp=1", vif.frame_start);
        end
        for (int i = 0; i < int'(FRAME0); i++) begin
            hs_n += int'(vif.hsync); vs_n += int'(vif.vsync);
            hb_n += int'(vif.hblnk); vb_n += int'(vif.vblnk);
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL m0_pixel got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (vif.frame_start !== 1'b1 || hs_n != 60 || vs_n != 64 || hb_n != 180 || vb_n != 160) begin
            failures++;
            $display("[TB] FAIL m0_frame_totals got fs=%b hs=%0d vs=%0d hb=%0d vb=%0d exp fs=1 hs=60 vs=64 hb=180 vb=160",
                     vif.frame_start, hs_n, vs_n, hb_n, vb_n);
        end
    endtask

    task automatic test_mode_switch();
        bit hit;
        bit early = 1'b0;
        int hs_lo = 0, vs_lo = 0, hb_n = 0, vb_n = 0;
        wait_v(7, hit);
        checks++;
        if (!hit) begin
            failures++;
            $display("[TB] FAIL sw_wait_v7 got=timeout exp=reached");
        end
        vif.mode_sel = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL sw_pixel got=%h exp=%h", obs(), expv());
            end
            if (vif.frame_start) break;
            if (vif.mode_act) early = 1'b1;
        end
        checks++;
        if (early || vif.frame_start !== 1'b1 || vif.mode_act !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sw_boundary got early=%b fs=%b act=%b exp early=0 fs=1 act=1",
                     early, vif.frame_start, vif.mode_act);
        end
        for (int i = 0; i < int'(FRAME1); i++) begin
            hs_lo += int'(!vif.hsync); vs_lo += int'(!vif.vsync);
            hb_n  += int'(vif.hblnk);  vb_n  += int'(vif.vblnk);
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL m1_pixel got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (vif.frame_start !== 1'b1 || hs_lo != 60 || vs_lo != 20 || hb_n != 80 || vb_n != 80) begin
            failures++;
            $display("[TB] FAIL m1_frame_totals got fs=%b hs_lo=%0d vs_lo=%0d hb=%0d vb=%0d exp fs=1 hs_lo=60 vs_lo=20 hb=80 vb=80",
                     vif.frame_start, hs_lo, vs_lo, hb_n, vb_n);
        end
    endtask

    task automatic test_aborted_request();
        for (int i = 0; i < int'(FRAME1); i++) begin
            if (i == 40) vif.mode_sel = 1'b0;
            if (i == 80) vif.mode_sel = 1'b1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL abort_pixel got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (vif.frame_start !== 1'b1 || vif.mode_act !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_no_switch got fs=%b act=%b exp fs=1 act=1",
                     vif.frame_start, vif.mode_act);
        end
    endtask

    task automatic test_random_modes();
        int left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                vif.mode_sel = 1'($urandom_range(0, 1));
                left = int'($urandom_range(30, 700));
            end
            left--;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL rand_pixel got=%h exp=%h", obs(), expv());
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (vif.frame_cnt !== 16'(mfcnt)) begin
                failures++;
                $display("[TB] FAIL rand_frame_cnt got=%0d exp=%0d", vif.frame_cnt, mfcnt);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit = 1'b0;
        vif.mode_sel = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (vif.mode_act === 1'b1 && vif.vcount == 11'd5) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("[TB] FAIL midrst_reach_m1 got=timeout exp=reached");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 28'd0) begin
            failures++;
            $display("[TB] FAIL midrst_async got=%h exp=%h", obs(), 28'd0);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (vif.frame_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midrst_frame_cnt_clear got=%0d exp=0", vif.frame_cnt);
        end
`endif
        tick();
        vif.mode_sel = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3 * int'(FRAME0); i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("[TB] FAIL midrst_pixel got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (vif.frame_start !== 1'b1 || vif.mode_act !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_three_frames got fs=%b act=%b exp fs=1 act=0",
                     vif.frame_start, vif.mode_act);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (vif.frame_cnt !== 16'd3) begin
            failures++;
            $display("[TB] FAIL midrst_frame_cnt got=%0d exp=3", vif.frame_cnt);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode0_frame();
        test_mode_switch();
        test_aborted_request();
        test_random_modes();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
